// File: rtl/ctrace_streamer.sv
// rtl/ctrace_streamer.sv - camera-trace transmit end: pixel FIFO, coordinate tagging, valid/commit beats, xof
// Pixels are buffered, then shown as a look-ahead valid beat followed by a commit beat.
module ctrace_streamer #(
   parameter int FP_SIZE      = 32,
   parameter int CAM_ROW_SIZE = 12,
   parameter int CAM_COL_SIZE = 12,
   parameter int N_ROW        = 8,
   parameter int N_COL        = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   input  logic                    pix_sof,
   input  logic [FP_SIZE-1:0]      pix_grn,
   input  logic [FP_SIZE-1:0]      pix_red,
   input  logic                    bank_busy,
   output logic                    ctrace_valid,
   output logic                    ctrace_commit,
   output logic [CAM_ROW_SIZE-1:0] ctrace_row,
   output logic [CAM_COL_SIZE-1:0] ctrace_col,
   output logic [FP_SIZE-1:0]      grn_ctrace,
   output logic [FP_SIZE-1:0]      red_ctrace,
   output logic                    xof,
   output logic                    frame_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 2 * FP_SIZE + 1;
   localparam logic [AW:0]             DEPTH    = (AW + 1)'(FIFO_DEPTH);
   localparam logic [CAM_ROW_SIZE-1:0] LAST_ROW = CAM_ROW_SIZE'(N_ROW - 1);
   localparam logic [CAM_COL_SIZE-1:0] LAST_COL = CAM_COL_SIZE'(N_COL - 1);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PRESENT = 2'd1;
   localparam logic [1:0] S_COMMIT  = 2'd2;
   localparam logic [1:0] S_EOF     = 2'd3;

   logic [EW-1:0]           mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]             count_q, count_d;
   logic                    pix_ready_q, pix_ready_d;
   logic [1:0]              state_q, state_d;
   logic [CAM_ROW_SIZE-1:0] row_q, row_d, crow_q, crow_d;
   logic [CAM_COL_SIZE-1:0] col_q, col_d, ccol_q, ccol_d;
   logic [FP_SIZE-1:0]      grn_q, grn_d, red_q, red_d;
   logic                    valid_q, valid_d, commit_q, commit_d, xof_q, xof_d, err_q, err_d;

   logic                    push, pop, go_present, last_pix, sof_bad;
   logic [EW-1:0]           head;
   logic [CAM_ROW_SIZE-1:0] nxt_row, cur_row;
   logic [CAM_COL_SIZE-1:0] nxt_col, cur_col;

   always_comb begin
      push        = pix_valid & pix_ready_q;
      pop         = (state_q == S_PRESENT);
      wr_ptr_d    = wr_ptr_q + AW'(push);
      rd_ptr_d    = rd_ptr_q + AW'(pop);
      count_d     = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      pix_ready_d = (count_d != DEPTH);
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= {pix_sof, pix_grn, pix_red};
   end

   // Coordinates of the pixel after the one on the outputs; in COMMIT the next
   // presentation must use these before row_q/col_q have been updated.
   always_comb begin
      head     = mem_q[rd_ptr_q];
      last_pix = (crow_q == LAST_ROW) && (ccol_q == LAST_COL);
      nxt_col  = (ccol_q == LAST_COL) ? '0 : ccol_q + CAM_COL_SIZE'(1);
      nxt_row  = (ccol_q != LAST_COL) ? crow_q :
                 (crow_q == LAST_ROW) ? '0 : crow_q + CAM_ROW_SIZE'(1);
      cur_row  = (state_q == S_COMMIT) ? nxt_row : row_q;
      cur_col  = (state_q == S_COMMIT) ? nxt_col : col_q;
      sof_bad  = head[EW-1] && ((cur_row != '0) || (cur_col != '0));
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      crow_d     = crow_q;
      ccol_d     = ccol_q;
      grn_d      = grn_q;
      red_d      = red_q;
      err_d      = err_q;
      valid_d    = 1'b0;
      commit_d   = 1'b0;
      xof_d      = 1'b0;
      go_present = 1'b0;
      case (state_q)
         S_IDLE:    go_present = (count_q != '0) && !bank_busy;
         S_PRESENT: begin
            state_d  = S_COMMIT;
            commit_d = 1'b1;
         end
         S_COMMIT: begin
            row_d = nxt_row;
            col_d = nxt_col;
            if (last_pix) begin
               state_d = S_EOF;
               xof_d   = 1'b1;
            end else if ((count_q != '0) && !bank_busy) begin
               go_present = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default:   state_d = S_IDLE;
      endcase
      if (go_present) begin
         state_d = S_PRESENT;
         valid_d = 1'b1;
         grn_d   = head[EW-2 -: FP_SIZE];
         red_d   = head[FP_SIZE-1:0];
         // A stray sof restarts the frame here; the truncated frame never gets an xof.
         if (sof_bad) begin
            err_d  = 1'b1;
            crow_d = '0;
            ccol_d = '0;
         end else begin
            crow_d = cur_row;
            ccol_d = cur_col;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pix_ready_q <= 1'b0;
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         crow_q      <= '0;
         ccol_q      <= '0;
         grn_q       <= '0;
         red_q       <= '0;
         valid_q     <= 1'b0;
         commit_q    <= 1'b0;
         xof_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pix_ready_q <= pix_ready_d;
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         crow_q      <= crow_d;
         ccol_q      <= ccol_d;
         grn_q       <= grn_d;
         red_q       <= red_d;
         valid_q     <= valid_d;
         commit_q    <= commit_d;
         xof_q       <= xof_d;
         err_q       <= err_d;
      end
   end

   assign pix_ready     = pix_ready_q;
   assign ctrace_valid  = valid_q;
   assign ctrace_commit = commit_q;
   assign ctrace_row    = crow_q;
   assign ctrace_col    = ccol_q;
   assign grn_ctrace    = grn_q;
   assign red_ctrace    = red_q;
   assign xof           = xof_q;
   assign frame_err     = err_q;
endmodule

// File: tb/tb_ctrace_streamer.sv
// tb/tb_ctrace_streamer.sv - randomized bench for ctrace_streamer against a pixel-index frame model
// Expected coordinates come from a per-frame pixel index (row = idx / N_COL, col = idx % N_COL).
module tb_ctrace_streamer;
   localparam int FP = 32;
   localparam int RW = 12;
   localparam int CW = 12;
   localparam int NR = 2;
   localparam int NC = 4;
   localparam int TOTAL = NR * NC;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          pix_valid = 1'b0, pix_sof = 1'b0, bank_busy = 1'b0;
   logic [FP-1:0] pix_grn = '0, pix_red = '0;
   logic          pix_ready, ctrace_valid, ctrace_commit, xof, frame_err;
   logic [RW-1:0] ctrace_row;
   logic [CW-1:0] ctrace_col;
   logic [FP-1:0] grn_ctrace, red_ctrace;

   ctrace_streamer #(.FP_SIZE(FP), .CAM_ROW_SIZE(RW), .CAM_COL_SIZE(CW),
                     .N_ROW(NR), .N_COL(NC), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .RESET(RESET), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_sof(pix_sof), .pix_grn(pix_grn), .pix_red(pix_red), .bank_busy(bank_busy),
      .ctrace_valid(ctrace_valid), .ctrace_commit(ctrace_commit), .ctrace_row(ctrace_row),
      .ctrace_col(ctrace_col), .grn_ctrace(grn_ctrace), .red_ctrace(red_ctrace),
      .xof(xof), .frame_err(frame_err));

   always #5 CLK = ~CLK;

   typedef struct {
      logic          sof;
      logic [FP-1:0] grn;
      logic [FP-1:0] red;
   } pix_t;

   pix_t exp_q[$];
   int   n_checks = 0, n_errors = 0;
   int   idx = 0, seq = 0, sof_seq = -1;
   bit   err_exp = 0, xof_due = 0, prev_valid = 0, mon_en = 0;
   int   commit_cnt = 0, valid_cnt = 0, xof_cnt = 0;
   logic [RW-1:0] sv_row;
   logic [CW-1:0] sv_col;
   logic [FP-1:0] sv_grn, sv_red;

   bit src_en = 0, busy_toggle = 0;
   int src_left = 0, src_rate = 100;

   always @(negedge CLK) begin
      if (busy_toggle) bank_busy = ~bank_busy;
      if (src_en) begin
         if (src_left > 0 && $urandom_range(0, 99) < src_rate) begin
            pix_valid = 1'b1;
            pix_grn   = FP'(seq + 1);
            pix_red   = $urandom;
            pix_sof   = (seq == sof_seq);
            if (pix_ready) begin
               exp_q.push_back('{pix_sof, pix_grn, pix_red});
               seq++;
               src_left--;
            end
         end else begin
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      if (mon_en) begin
         pix_t e;
         n_checks++;
         if (ctrace_valid && ctrace_commit) begin
            n_errors++;
            $display("FAIL overlap: valid=%0b commit=%0b, required not both", ctrace_valid, ctrace_commit);
         end
         n_checks++;
         if (xof !== xof_due) begin
            n_errors++;
            $display("FAIL xof: got %0b required %0b (idx %0d)", xof, xof_due, idx);
         end
         if (xof === 1'b1) xof_cnt++;
         xof_due = 0;
         if (prev_valid) begin
            n_checks++;
            if (ctrace_commit !== 1'b1 || ctrace_row !== sv_row || ctrace_col !== sv_col ||
                grn_ctrace !== sv_grn || red_ctrace !== sv_red) begin
               n_errors++;
               $display("FAIL pair: commit=%0b row/col %0d/%0d grn %h, required 1 %0d/%0d %h",
                        ctrace_commit, ctrace_row, ctrace_col, grn_ctrace, sv_row, sv_col, sv_grn);
            end
         end else if (ctrace_commit) begin
            n_checks++;
            n_errors++;
            $display("FAIL orphan_commit: commit=1 without preceding valid, required 0");
         end
         if (ctrace_valid === 1'b1) valid_cnt++;
         if (ctrace_commit === 1'b1) begin
            commit_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL extra_pixel: grn %h committed, required no pixel", grn_ctrace);
            end else begin
               e = exp_q.pop_front();
               if (e.sof && idx != 0) begin
                  err_exp = 1;
                  idx = 0;
               end
               if (ctrace_row !== RW'(idx / NC) || ctrace_col !== CW'(idx % NC) ||
                   grn_ctrace !== e.grn || red_ctrace !== e.red || frame_err !== err_exp) begin
                  n_errors++;
                  $display("FAIL pixel: row %0d col %0d grn %h red %h err %0b, required %0d %0d %h %h %0b",
                           ctrace_row, ctrace_col, grn_ctrace, red_ctrace, frame_err,
                           idx / NC, idx % NC, e.grn, e.red, err_exp);
               end
               if (idx == TOTAL - 1) xof_due = 1;
               idx = (idx + 1) % TOTAL;
            end
         end
         prev_valid = (ctrace_valid === 1'b1);
         sv_row = ctrace_row;
         sv_col = ctrace_col;
         sv_grn = grn_ctrace;
         sv_red = red_ctrace;
      end
   end

   task automatic wait_drain(input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (src_left == 0 && exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({pix_ready, ctrace_valid, ctrace_commit, xof, frame_err, ctrace_row, ctrace_col,
           grn_ctrace, red_ctrace} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: ready %0b valid %0b row %0d grn %h, required all 0",
                  pix_ready, ctrace_valid, ctrace_row, grn_ctrace);
      end
      RESET = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (pix_ready !== 1'b1 || ctrace_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release: ready %0b valid %0b, required 1 0", pix_ready, ctrace_valid);
      end
      mon_en = 1;
   endtask

   task automatic test_frame;
      bit ok;
      int c0 = commit_cnt, x0 = xof_cnt;
      bank_busy = 0;
      src_rate = 100;
      src_left = 8;
      src_en = 1;
      wait_drain(200, ok);
      n_checks++;
      if (!ok || commit_cnt - c0 != 8) begin
         n_errors++;
         $display("FAIL frame_count: drained %0b commits %0d, required 1 8", ok, commit_cnt - c0);
      end
      n_checks++;
      if (xof_cnt - x0 != 1) begin
         n_errors++;
         $display("FAIL frame_xof: xof pulses %0d, required 1", xof_cnt - x0);
      end
   endtask

   task automatic test_latency;
      src_en = 0;
      repeat (2) @(negedge CLK);
      pix_valid = 1'b1;
      pix_sof   = 1'b0;
      pix_grn   = FP'(seq + 1);
      pix_red   = $urandom;
      n_checks++;
      if (pix_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL lat_ready: ready %0b, required 1", pix_ready);
      end else begin
         exp_q.push_back('{1'b0, pix_grn, pix_red});
         seq++;
      end
      @(negedge CLK);
      pix_valid = 1'b0;
      n_checks++;
      if (ctrace_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL lat_t0: valid %0b after push edge, required 0", ctrace_valid);
      end
      @(negedge CLK);
      n_checks++;
      if (ctrace_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL lat_valid: valid %0b after edge t+1, required 1", ctrace_valid);
      end
      @(negedge CLK);
      n_checks++;
      if (ctrace_commit !== 1'b1) begin
         n_errors++;
         $display("FAIL lat_commit: commit %0b after edge t+2, required 1", ctrace_commit);
      end
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_full;
      bit ok;
      int v0 = valid_cnt, c0;
      bank_busy = 1;
      src_rate = 100;
      src_left = 6;
      src_en = 1;
      repeat (12) @(negedge CLK);
      n_checks++;
      if (pix_ready !== 1'b0 || exp_q.size() != 4 || valid_cnt != v0) begin
         n_errors++;
         $display("FAIL full: ready %0b accepted %0d valids %0d, required 0 4 0",
                  pix_ready, exp_q.size(), valid_cnt - v0);
      end
      src_left = 0;
      c0 = commit_cnt;
      bank_busy = 0;
      wait_drain(100, ok);
      n_checks++;
      if (!ok || commit_cnt - c0 != 4 || pix_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL full_drain: drained %0b commits %0d ready %0b, required 1 4 1",
                  ok, commit_cnt - c0, pix_ready);
      end
   endtask

   task automatic test_busy_toggle;
      bit ok;
      int c0 = commit_cnt;
      busy_toggle = 1;
      src_rate = 60;
      src_left = 19;
      src_en = 1;
      wait_drain(1000, ok);
      busy_toggle = 0;
      bank_busy = 0;
      n_checks++;
      if (!ok || commit_cnt - c0 != 19) begin
         n_errors++;
         $display("FAIL toggle: drained %0b commits %0d, required 1 19", ok, commit_cnt - c0);
      end
   endtask

   task automatic test_sof_err;
      bit ok;
      int x0 = xof_cnt;
      sof_seq = seq + 2;
      src_rate = 80;
      src_left = 10;
      src_en = 1;
      wait_drain(400, ok);
      n_checks++;
      if (!ok || frame_err !== 1'b1) begin
         n_errors++;
         $display("FAIL sof_err: drained %0b frame_err %0b, required 1 1", ok, frame_err);
      end
      n_checks++;
      if (xof_cnt - x0 != 1) begin
         n_errors++;
         $display("FAIL sof_xof: xof pulses %0d, required 1", xof_cnt - x0);
      end
      sof_seq = -1;
   endtask

   task automatic test_mid_reset;
      bit ok, seen = 0;
      int c0, v0;
      bank_busy = 1;
      src_rate = 100;
      src_left = 3;
      src_en = 1;
      for (int i = 0; i < 20 && src_left != 0; i++) @(negedge CLK);
      bank_busy = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLK);
         seen = (ctrace_valid === 1'b1);
      end
      mon_en = 0;
      n_checks++;
      if (!seen || exp_q.size() != 3) begin
         n_errors++;
         $display("FAIL mid_setup: present %0b buffered %0d, required 1 3", seen, exp_q.size());
      end
      #2 RESET = 1'b0;
      #1;
      n_checks++;
      if ({pix_ready, ctrace_valid, ctrace_commit, xof, frame_err, ctrace_row, ctrace_col,
           grn_ctrace, red_ctrace} !== '0) begin
         n_errors++;
         $display("FAIL mid_reset: ready %0b valid %0b err %0b grn %h, required all 0",
                  pix_ready, ctrace_valid, frame_err, grn_ctrace);
      end
      exp_q.delete();
      idx = 0;
      err_exp = 0;
      xof_due = 0;
      prev_valid = 0;
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      mon_en = 1;
      c0 = commit_cnt;
      v0 = valid_cnt;
      src_left = 1;
      wait_drain(100, ok);
      repeat (10) @(negedge CLK);
      n_checks++;
      if (!ok || commit_cnt - c0 != 1 || valid_cnt - v0 != 1 || frame_err !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_after: drained %0b commits %0d valids %0d err %0b, required 1 1 1 0",
                  ok, commit_cnt - c0, valid_cnt - v0, frame_err);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_latency();
      test_full();
      test_busy_toggle();
      test_sof_err();
      test_mid_reset();
      src_en = 0;
      mon_en = 0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
